// File: rtl/serial_sub.sv
// serial_sub: multi-cycle two's complement subtractor (diff = a - b).
// The operands are processed CHUNK bits per cycle, least significant chunk
// first, by adding a to the bitwise inverse of b with an initial carry of 1.
// A valid/ready handshake is used on both the operand and the result side.
// WIDTH must be a multiple of CHUNK.
// Optional feature: define SUB_SAT_EN to clamp an overflowing result to the
// largest positive or most negative value instead of letting it wrap.
module serial_sub #(
  parameter int WIDTH = 20,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bInv_q, bInv_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] aChunk;
  logic [CHUNK-1:0] bChunk;
  logic [CHUNK:0]   chunkSum;
  logic [WIDTH-1:0] diffMerged;
  logic [WIDTH-1:0] resultFinal;
  logic             aSign;
  logic             bSign;
  logic             ovfNext;

  // Pick the operand chunks addressed by the chunk counter.
  always_comb begin
    aChunk = '0;
    bChunk = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        aChunk = a_q[k*CHUNK +: CHUNK];
        bChunk = bInv_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // One ripple step: chunk of a plus chunk of inverted b plus the running carry.
  assign chunkSum = {1'b0, aChunk} + {1'b0, bChunk} + (CHUNK+1)'(carry_q);

  // Partial result with the freshly computed chunk written into its slot.
  always_comb begin
    diffMerged = diff_q;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        diffMerged[k*CHUNK +: CHUNK] = chunkSum[CHUNK-1:0];
      end
    end
  end

  // Signed overflow: operands of different sign and a result whose sign
  // does not follow the minuend. b's sign is recovered from its inverse.
  assign aSign   = a_q[WIDTH-1];
  assign bSign   = ~bInv_q[WIDTH-1];
  assign ovfNext = (aSign != bSign) && (diffMerged[WIDTH-1] != aSign);

`ifdef SUB_SAT_EN
  // Clamp an overflowing result towards the sign of the minuend.
  always_comb begin
    resultFinal = diffMerged;
    if (ovfNext) begin
      resultFinal = aSign ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign resultFinal = diffMerged;
`endif

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bInv_d  = bInv_q;
    diff_d  = diff_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          bInv_d  = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          diff_d  = '0;
          zero_d  = 1'b0;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        carry_d = chunkSum[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CHUNK) begin
          diff_d  = resultFinal;
          zero_d  = (resultFinal == '0);
          neg_d   = resultFinal[WIDTH-1];
          ovf_d   = ovfNext;
          state_d = DONE;
        end else begin
          diff_d  = diffMerged;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      bInv_q  <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bInv_q  <= bInv_d;
      diff_q  <= diff_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and randomised checks of serial_sub against an
// arithmetic model of signed subtraction (optionally saturating when
// SUB_SAT_EN is defined), plus hand-computed expectations for key vectors.
module tb_serial_sub;

  localparam int WIDTH = 20;
  localparam int CHUNK = 4;
  localparam int NCH   = WIDTH / CHUNK;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] diff;
  logic             zero;
  logic             neg;
  logic             ovf;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference result from signed integer arithmetic on the operands.
  function automatic void modelSub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   output logic [WIDTH-1:0] d, output logic z,
                                   output logic n, output logic o);
    longint sx, sy, sd, maxV, minV;
    maxV = (longint'(1) << (WIDTH-1)) - 1;
    minV = -(longint'(1) << (WIDTH-1));
    sx = x[WIDTH-1] ? longint'(x) - (longint'(1) << WIDTH) : longint'(x);
    sy = y[WIDTH-1] ? longint'(y) - (longint'(1) << WIDTH) : longint'(y);
    sd = sx - sy;
    o  = (sd > maxV) || (sd < minV);
`ifdef SUB_SAT_EN
    if (sd > maxV) sd = maxV;
    else if (sd < minV) sd = minV;
`endif
    d = WIDTH'(sd);
    z = (d == '0);
    n = d[WIDTH-1];
  endfunction

  // Transaction-level timing model: busy for NCH edges after acceptance,
  // then holding a result until the consumer takes it.
  logic             mBusy  = 1'b0;
  logic             mHold  = 1'b0;
  logic             mClean = 1'b1;
  int               mEdges = 0;
  logic [WIDTH-1:0] mA     = '0;
  logic [WIDTH-1:0] mB     = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy  <= 1'b0;
      mHold  <= 1'b0;
      mClean <= 1'b1;
      mEdges <= 0;
    end else if (mHold) begin
      if (out_ready) mHold <= 1'b0;
    end else if (mBusy) begin
      if (mEdges == NCH - 1) begin
        mBusy <= 1'b0;
        mHold <= 1'b1;
      end
      mEdges <= mEdges + 1;
    end else if (in_valid) begin
      mBusy  <= 1'b1;
      mEdges <= 0;
      mA     <= a;
      mB     <= b;
      mClean <= 1'b0;
    end
  end

  // Every falling edge out of reset: handshake and result against the model.
  logic [WIDTH-1:0] eD;
  logic             eZ, eN, eO;
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("out_valid", out_valid, mHold);
      checkOutput("in_ready", in_ready, !mBusy && !mHold);
      if (mHold) begin
        modelSub(mA, mB, eD, eZ, eN, eO);
        checkOutput("diff", diff, eD);
        checkOutput("zero", zero, eZ);
        checkOutput("neg", neg, eN);
        checkOutput("ovf", ovf, eO);
      end else if (mClean) begin
        checkOutput("diff after reset", diff, 0);
        checkOutput("flags after reset", {zero, neg, ovf}, 0);
      end
    end
  end

  // Present one operand pair, scramble inputs while busy, optionally stall
  // the consumer for holdCycles, and return the result seen when valid.
  task automatic applyStimulus(input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                               input int holdCycles,
                               output logic [WIDTH-1:0] dOut, output logic zOut,
                               output logic nOut, output logic oOut, output int latency);
    dOut = '0; zOut = 1'b0; nOut = 1'b0; oOut = 1'b0;
    @(negedge clk);
    a         = aV;
    b         = bV;
    in_valid  = 1'b1;
    out_ready = (holdCycles == 0);
    latency   = 0;
    do begin
      @(negedge clk);
      latency++;
      if (!out_valid) begin
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
    end while (!out_valid && latency < 50);
    if (!out_valid) begin
      checkOutput("out_valid timeout", 0, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      return;
    end
    dOut = diff; zOut = zero; nOut = neg; oOut = ovf;
    in_valid = 1'($urandom_range(0, 1));
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      in_valid = 1'($urandom_range(0, 1));
    end
    if (holdCycles > 0) begin
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("in_ready after result taken", in_ready, 1);
  endtask

  logic [WIDTH-1:0] rD;
  logic             rZ, rN, rO;
  int               lat;
  logic             prevOv;
  int               lastRise;
  int               gaps;

  initial begin
    rst_n = 1'b0;
    #2;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset diff", diff, 0);
    checkOutput("reset flags", {zero, neg, ovf}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(20'h00005, 20'h00003, 0, rD, rZ, rN, rO, lat);
    checkOutput("5-3 latency", lat, NCH + 1);
    checkOutput("5-3 diff", rD, 20'h00002);
    checkOutput("5-3 flags", {rZ, rN, rO}, 3'b000);

    applyStimulus(20'h00000, 20'h00001, 0, rD, rZ, rN, rO, lat);
    checkOutput("0-1 diff", rD, 20'hFFFFF);
    checkOutput("0-1 neg", rN, 1);
    checkOutput("0-1 ovf", rO, 0);

    applyStimulus(20'h12345, 20'h12345, 0, rD, rZ, rN, rO, lat);
    checkOutput("equal diff", rD, 20'h00000);
    checkOutput("equal zero", rZ, 1);

    applyStimulus(20'h7FFFF, 20'hFFFFF, 0, rD, rZ, rN, rO, lat);
    checkOutput("max-(-1) ovf", rO, 1);
`ifdef SUB_SAT_EN
    checkOutput("max-(-1) diff", rD, 20'h7FFFF);
    checkOutput("max-(-1) neg", rN, 0);
`else
    checkOutput("max-(-1) diff", rD, 20'h80000);
    checkOutput("max-(-1) neg", rN, 1);
`endif

    applyStimulus(20'h80000, 20'h00001, 1, rD, rZ, rN, rO, lat);
    checkOutput("min-1 ovf", rO, 1);
`ifdef SUB_SAT_EN
    checkOutput("min-1 diff", rD, 20'h80000);
`else
    checkOutput("min-1 diff", rD, 20'h7FFFF);
`endif

    applyStimulus(20'h0ABCD, 20'h12345, 10, rD, rZ, rN, rO, lat);
    checkOutput("stall diff", rD, 20'hF8888);
    checkOutput("stall flags", {rZ, rN, rO}, 3'b010);

    // Reset pulse inside the third RUN cycle, checked before any clock edge.
    @(negedge clk);
    a = 20'h00AAA; b = 20'h00555; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset in_ready", in_ready, 1);
    checkOutput("async reset diff", diff, 0);
    checkOutput("async reset flags", {zero, neg, ovf}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after release", in_ready, 1);

    applyStimulus(20'h00010, 20'h00001, 0, rD, rZ, rN, rO, lat);
    checkOutput("post-reset diff", rD, 20'h0000F);

    applyStimulus(20'h00000, 20'h80000, 0, rD, rZ, rN, rO, lat);
    checkOutput("0-min ovf", rO, 1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 3),
                    rD, rZ, rN, rO, lat);
    end

    // Back-to-back: in_valid held high, results should be NCH+2 cycles apart.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prevOv    = 1'b0;
    lastRise  = -1;
    gaps      = 0;
    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      @(negedge clk);
      if (out_valid && !prevOv) begin
        if (lastRise >= 0) begin
          checkOutput("throughput gap", i - lastRise, NCH + 2);
          gaps++;
        end
        lastRise = i;
      end
      prevOv = out_valid;
    end
    in_valid = 1'b0;
    checkOutput("throughput results seen", gaps >= 3, 1);

    for (int i = 0; i < 20 && !(in_ready && !out_valid); i++) begin
      @(negedge clk);
    end
    checkOutput("final idle", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
